// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_is_div(op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_rs1_signed(op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_rs2_signed(op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand abs values and result sign fix-up.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: one bit per cycle, valid/ready on both sides.
// Build option MULDIV_FAST_MUL_EN computes multiplies in a single cycle with the native operator.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_1,
  input  logic [XLEN-1:0] i_2,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_1,
  output logic            o_busy
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  op_e    op_in;
  logic   s1, s2, neg_in;
  logic   [XLEN-1:0] abs1, abs2;

  assign op_in  = op_e'(i_op);
  assign s1     = i_1[XLEN-1] & op_rs1_signed(op_in);
  assign s2     = i_2[XLEN-1] & op_rs2_signed(op_in);
  assign neg_in = (op_in == OP_MULHSU || op_in == OP_REM) ? s1 : (s1 ^ s2);

  muldiv_negate #(.W(XLEN)) u_abs1 (.neg(s1), .a(i_1), .y(abs1));
  muldiv_negate #(.W(XLEN)) u_abs2 (.neg(s2), .a(i_2), .y(abs2));

  // Cases RISC-V defines explicitly; they bypass the iterative datapath.
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign div_zero = op_is_div(op_in) && (i_2 == '0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (i_1 == MIN_INT) && (i_2 == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)               special_res = op_is_rem(op_in) ? i_1 : '1;
    else if (!op_is_rem(op_in)) special_res = MIN_INT;
  end

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  op_e               op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;   // multiplicand for mul, divisor for div
  logic [2*XLEN-1:0] acc;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc_nxt;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;

  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
  assign div_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge  = div_sh >= {1'b0, opnd_q};
  // The difference is always below the divisor, so the truncated subtract is exact.
  assign div_rem = div_ge ? (div_sh[XLEN-1:0] - opnd_q) : div_sh[XLEN-1:0];
  assign acc_nxt = op_is_div(op_q) ? {div_rem, acc[XLEN-2:0], div_ge}
                                   : {mul_sum, acc[XLEN-1:1]};

  logic [2*XLEN-1:0] prod_src, prod_fix;
  logic              prod_neg;
  logic [XLEN-1:0]   div_src, div_fix, calc_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;
  assign fast_prod = {{XLEN{1'b0}}, abs1} * {{XLEN{1'b0}}, abs2};
  assign prod_src  = (state == S_IDLE) ? fast_prod : acc_nxt;
  assign prod_neg  = (state == S_IDLE) ? neg_in : neg_q;
  assign fast_res  = (op_in == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`else
  assign prod_src = acc_nxt;
  assign prod_neg = neg_q;
`endif

  muldiv_negate #(.W(2*XLEN)) u_prod_fix (.neg(prod_neg), .a(prod_src), .y(prod_fix));

  assign div_src = op_is_rem(op_q) ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
  muldiv_negate #(.W(XLEN)) u_div_fix (.neg(neg_q), .a(div_src), .y(div_fix));

  always_comb begin
    calc_res = div_fix;
    case (op_q)
      OP_MUL:                      calc_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
      default:                     calc_res = div_fix;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      acc     <= '0;
      o_valid <= 1'b0;
      o_1     <= '0;
      o_busy  <= 1'b0;
      o_ready <= 1'b1;
    end else if (i_kill) begin
      state   <= S_IDLE;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            op_q   <= op_in;
            neg_q  <= neg_in;
            opnd_q <= op_is_div(op_in) ? abs2 : abs1;
            acc    <= {{XLEN{1'b0}}, (op_is_div(op_in) ? abs1 : abs2)};
            cnt    <= '0;
            o_busy <= 1'b1;
            o_ready <= 1'b0;
            if (special) begin
              state   <= S_DONE;
              o_valid <= 1'b1;
              o_1     <= special_res;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!op_is_div(op_in)) begin
              state   <= S_DONE;
              o_valid <= 1'b1;
              o_1     <= fast_res;
            end
`endif
            else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN-1)) begin
            state   <= S_DONE;
            o_valid <= 1'b1;
            o_1     <= calc_res;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            state   <= S_IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_seq;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = XLEN;
`endif
  localparam int DIV_LAT = XLEN;

  logic            i_clk = 1'b0;
  logic            i_rst, i_valid, o_ready, i_kill, o_valid, i_ready, o_busy;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_1, i_2, o_1;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_1(i_1), .i_2(i_2), .i_kill(i_kill),
    .o_valid(o_valid), .i_ready(i_ready), .o_1(o_1), .o_busy(o_busy)
  );

  // Drive one request and collect the result. lat counts clock edges after the
  // accept edge until o_valid is seen (0 = valid in the cycle right after accept).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    i_op = op; i_1 = a; i_2 = b; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_1 = $urandom; i_2 = $urandom; i_op = 3'($urandom);
    lat = 0;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
    res = o_1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_1 !== 32'h0) begin errors++; $display("FAIL reset_o1: got %h expected 00000000", o_1); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    i_rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  op [5];
    logic [31:0] a [5], b [5], expv [5];
    logic [31:0] res;
    int lat;
    op   = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b001};
    a    = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    b    = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    expv = '{32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000};
    for (int k = 0; k < 5; k++) begin
      do_op(op[k], a[k], b[k], res, lat);
      checks++;
      if (res !== expv[k]) begin errors++; $display("FAIL mul[%0d]: got %h expected %h", k, res, expv[k]); end
      checks++;
      if (lat != MUL_LAT) begin errors++; $display("FAIL mul_lat[%0d]: got %0d expected %0d", k, lat, MUL_LAT); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  op [6];
    logic [31:0] a [6], b [6], expv [6];
    logic [31:0] res;
    int lat;
    op   = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
    a    = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    b    = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
    expv = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
    for (int k = 0; k < 6; k++) begin
      do_op(op[k], a[k], b[k], res, lat);
      checks++;
      if (res !== expv[k]) begin errors++; $display("FAIL div[%0d]: got %h expected %h", k, res, expv[k]); end
      checks++;
      if (lat != DIV_LAT) begin errors++; $display("FAIL div_lat[%0d]: got %0d expected %0d", k, lat, DIV_LAT); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  op [6];
    logic [31:0] a [6], b [6], expv [6];
    logic [31:0] res;
    int lat;
    op   = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b101, 3'b110};
    a    = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFF9};
    b    = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    expv = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9};
    for (int k = 0; k < 6; k++) begin
      do_op(op[k], a[k], b[k], res, lat);
      checks++;
      if (res !== expv[k]) begin errors++; $display("FAIL special[%0d]: got %h expected %h", k, res, expv[k]); end
      checks++;
      if (lat != 0) begin errors++; $display("FAIL special_lat[%0d]: got %0d expected 0", k, lat); end
    end
  endtask

  task automatic test_backpressure();
    int wait_cnt;
    i_op = 3'b101; i_1 = 32'd100; i_2 = 32'd7; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    wait_cnt = 0;
    while (!o_valid && wait_cnt < 100) begin
      @(posedge i_clk); #1;
      wait_cnt++;
    end
    checks++;
    if (!o_valid) begin errors++; $display("FAIL bp_timeout: got o_valid %b expected 1", o_valid); end
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_op = 3'b000; i_1 = 32'd3; i_2 = 32'd3;
      @(posedge i_clk); #1;
      checks++;
      if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, o_valid); end
      checks++;
      if (o_1 !== 32'd14) begin errors++; $display("FAIL bp_o1[%0d]: got %h expected 0000000e", k, o_1); end
      checks++;
      if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", k, o_ready); end
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", o_ready); end
    @(posedge i_clk); #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bp_no_new_op: got busy %b expected 0", o_busy); end
  endtask

  task automatic test_kill_rst();
    logic [31:0] res;
    int lat;
    logic seen;
    i_op = 3'b101; i_1 = 32'd100; i_2 = 32'd7; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_kill = 1'b1;
    @(posedge i_clk); #1;
    i_kill = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL kill_busy: got %b expected 0", o_busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL kill_ready: got %b expected 1", o_ready); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL kill_no_result: got %b expected 0", seen); end

    // Kill in the same cycle as a request must win over acceptance.
    i_op = 3'b100; i_1 = 32'd9; i_2 = 32'd3; i_valid = 1'b1; i_kill = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_kill = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL kill_vs_accept: got busy %b expected 0", o_busy); end

    i_op = 3'b100; i_1 = 32'hFFFFFFF9; i_2 = 32'd2; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
    checks++; if (o_1 !== 32'h0) begin errors++; $display("FAIL rst_o1: got %h expected 00000000", o_1); end

    do_op(3'b111, 32'd100, 32'd7, res, lat);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL post_rst_res: got %h expected 00000002", res); end
    checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL post_rst_lat: got %0d expected %0d", lat, DIV_LAT); end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_kill = 1'b0; i_ready = 1'b0;
    i_op = 3'b000; i_1 = '0; i_2 = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_kill_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
